// File: rtl/cc1200_pmod_bridge_if.sv
// rtl/cc1200_pmod_bridge_if.sv - Pmod pad-side signal bundle for the CC1200 bridge
interface cc1200_pmod_bridge_if #(
  parameter int GPIO_W = 4
);
  logic [GPIO_W-1:0] pad_gpio_o;
  logic [GPIO_W-1:0] pad_gpio_oe;
  logic [GPIO_W-1:0] pad_gpio_i;
  logic              pad_sclk_o;
  logic              pad_mosi_o;
  logic              pad_cs_n_o;
  logic              pad_spi_oe;
  logic              pad_miso_i;

  modport master (
    output pad_gpio_o, pad_gpio_oe, pad_sclk_o, pad_mosi_o, pad_cs_n_o, pad_spi_oe,
    input  pad_gpio_i, pad_miso_i
  );

  modport slave (
    input  pad_gpio_o, pad_gpio_oe, pad_sclk_o, pad_mosi_o, pad_cs_n_o, pad_spi_oe,
    output pad_gpio_i, pad_miso_i
  );
endinterface

// File: rtl/cc1200_pmod_bridge.sv
// rtl/cc1200_pmod_bridge.sv - CC1200 GPIO/SPI to Pmod bridge with debounced arm/drain enable
module cc1200_pmod_bridge #(
  parameter int GPIO_W       = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int GUARD_CYC    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_sw,
  input  logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_oe,
  output logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_rise,
  output logic [GPIO_W-1:0] gpio_fall,
  input  logic [GPIO_W-1:0] irq_mask,
  input  logic              irq_clr,
  output logic              irq,
  input  logic              spi_sclk_i,
  input  logic              spi_mosi_i,
  input  logic              spi_cs_n_i,
  output logic              spi_miso_o,
  cc1200_pmod_bridge_if.master pad,
  output logic [1:0]        link_state
);
  localparam int MAX_CYC = (DEBOUNCE_CYC > GUARD_CYC) ? DEBOUNCE_CYC : GUARD_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);

  // S_IDLE is the second half of draining: SPI pads parked before release
  typedef enum logic [2:0] {S_OFF, S_ARM, S_ON, S_DRAIN, S_IDLE} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     g_cnt, g_cnt_nx;
  logic [SYNC_STAGES-1:0] en_sync;
  logic              en_s, en_db;
  logic [CW-1:0]     db_cnt;
  logic [GPIO_W-1:0] gpio_sync [SYNC_STAGES];
  logic [GPIO_W-1:0] hist;
  logic              on_q;
  logic              edge_en;

  assign en_s = en_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      en_sync <= '0;
      en_db   <= 1'b0;
      db_cnt  <= '0;
    end else begin
      en_sync <= {en_sync[SYNC_STAGES-2:0], en_sw};
      if (en_s == en_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        en_db  <= ~en_db;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_OFF;
      g_cnt <= '0;
    end else begin
      state <= state_nx;
      g_cnt <= g_cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    g_cnt_nx = g_cnt;
    case (state)
      S_OFF: begin
        if (en_db) begin
          state_nx = S_ARM;
          g_cnt_nx = '0;
        end
      end
      S_ARM: begin
        if (!en_db)                 state_nx = S_OFF;
        else if (g_cnt == GUARD_LAST) state_nx = S_ON;
        else                        g_cnt_nx = g_cnt + 1'b1;
      end
      S_ON: begin
        if (!en_db) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        // en_db is deliberately ignored until OFF so a transaction is never cut
        if (spi_cs_n_i) begin
          state_nx = S_IDLE;
          g_cnt_nx = '0;
        end
      end
      S_IDLE: begin
        if (g_cnt == GUARD_LAST) state_nx = S_OFF;
        else                     g_cnt_nx = g_cnt + 1'b1;
      end
      default: state_nx = S_OFF;
    endcase
  end

  always_comb begin
    pad.pad_gpio_o  = '0;
    pad.pad_gpio_oe = '0;
    pad.pad_spi_oe  = 1'b0;
    pad.pad_sclk_o  = 1'b0;
    pad.pad_mosi_o  = 1'b0;
    pad.pad_cs_n_o  = 1'b1;
    spi_miso_o      = 1'b0;
    link_state      = 2'd0;
    case (state)
      S_ARM: begin
        pad.pad_spi_oe = 1'b1;
        link_state     = 2'd1;
      end
      S_ON: begin
        pad.pad_gpio_o  = gpio_out;
        pad.pad_gpio_oe = gpio_oe;
        pad.pad_spi_oe  = 1'b1;
        pad.pad_sclk_o  = spi_sclk_i;
        pad.pad_mosi_o  = spi_mosi_i;
        pad.pad_cs_n_o  = spi_cs_n_i;
        spi_miso_o      = pad.pad_miso_i;
        link_state      = 2'd2;
      end
      S_DRAIN: begin
        pad.pad_spi_oe = 1'b1;
        pad.pad_sclk_o = spi_sclk_i;
        pad.pad_mosi_o = spi_mosi_i;
        pad.pad_cs_n_o = spi_cs_n_i;
        spi_miso_o     = pad.pad_miso_i;
        link_state     = 2'd3;
      end
      S_IDLE: begin
        pad.pad_spi_oe = 1'b1;
        link_state     = 2'd3;
      end
      default: ;
    endcase
  end

  assign gpio_in = gpio_sync[SYNC_STAGES-1];
  // on_q masks the first ON cycle, where hist still holds pre-ON history
  assign edge_en   = (state == S_ON) && on_q;
  assign gpio_rise = gpio_in & ~hist & {GPIO_W{edge_en}};
  assign gpio_fall = ~gpio_in & hist & {GPIO_W{edge_en}};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) gpio_sync[i] <= '0;
      hist <= '0;
      on_q <= 1'b0;
      irq  <= 1'b0;
    end else begin
      gpio_sync[0] <= pad.pad_gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) gpio_sync[i] <= gpio_sync[i-1];
      hist <= gpio_in;
      on_q <= (state == S_ON);
      if (|((gpio_rise | gpio_fall) & irq_mask)) irq <= 1'b1;
      else if (irq_clr)                          irq <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cc1200_pmod_bridge.sv
// tb/tb_cc1200_pmod_bridge.sv - randomized and directed bench for cc1200_pmod_bridge
module tb_cc1200_pmod_bridge;
  localparam int S  = 2;
  localparam int DB = 8;
  localparam int G  = 4;

  logic       clk = 1'b0;
  logic       rst, en_sw, irq_clr, sclk_i, mosi_i, cs_n_i, miso_i;
  logic [7:0] gpio_out8, gpio_oe8, irq_mask8, pad_i8;
  logic [3:0] gin4, rise4, fall4;
  logic [7:0] gin8, rise8, fall8;
  logic       irq4, irq8, miso4, miso8;
  logic [1:0] ls4, ls8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cc1200_pmod_bridge_if #(.GPIO_W(4)) pads4 ();
  cc1200_pmod_bridge_if #(.GPIO_W(8)) pads8 ();
  assign pads4.pad_gpio_i = pad_i8[3:0];
  assign pads4.pad_miso_i = miso_i;
  assign pads8.pad_gpio_i = pad_i8;
  assign pads8.pad_miso_i = miso_i;

  cc1200_pmod_bridge #(.GPIO_W(4), .SYNC_STAGES(S), .DEBOUNCE_CYC(DB), .GUARD_CYC(G)) dut4 (
    .clk(clk), .rst(rst), .en_sw(en_sw), .gpio_out(gpio_out8[3:0]), .gpio_oe(gpio_oe8[3:0]),
    .gpio_in(gin4), .gpio_rise(rise4), .gpio_fall(fall4), .irq_mask(irq_mask8[3:0]),
    .irq_clr(irq_clr), .irq(irq4), .spi_sclk_i(sclk_i), .spi_mosi_i(mosi_i),
    .spi_cs_n_i(cs_n_i), .spi_miso_o(miso4), .pad(pads4.master), .link_state(ls4));

  cc1200_pmod_bridge #(.GPIO_W(8), .SYNC_STAGES(S), .DEBOUNCE_CYC(DB), .GUARD_CYC(G)) dut8 (
    .clk(clk), .rst(rst), .en_sw(en_sw), .gpio_out(gpio_out8), .gpio_oe(gpio_oe8),
    .gpio_in(gin8), .gpio_rise(rise8), .gpio_fall(fall8), .irq_mask(irq_mask8),
    .irq_clr(irq_clr), .irq(irq8), .spi_sclk_i(sclk_i), .spi_mosi_i(mosi_i),
    .spi_cs_n_i(cs_n_i), .spi_miso_o(miso8), .pad(pads8.master), .link_state(ls8));

  // Reference model: delay lines for the synchronisers, run-length debounce, phase + age
  bit         m_en_q[$];
  logic [7:0] m_pad_q[$];
  bit         m_en_db, m_idle, m_on_prev, m_irq4, m_irq8;
  int         m_run, m_phase, m_age;
  logic [7:0] m_hist;

  task automatic model_reset();
    m_en_q = {};
    m_pad_q = {};
    for (int i = 0; i < S; i++) begin
      m_en_q.push_back(1'b0);
      m_pad_q.push_back(8'h00);
    end
    m_en_db = 0; m_idle = 0; m_on_prev = 0; m_irq4 = 0; m_irq8 = 0;
    m_run = 0; m_phase = 0; m_age = 0; m_hist = 8'h00;
  endtask

  function automatic logic [7:0] m_edges(input bit rising);
    logic [7:0] gin;
    gin = m_pad_q[S-1];
    if (!(m_phase == 2 && m_on_prev)) return 8'h00;
    return rising ? (gin & ~m_hist) : (~gin & m_hist);
  endfunction

  task automatic model_edge();
    logic [7:0] ev;
    bit en_s;
    if (rst) begin
      model_reset();
      return;
    end
    en_s = m_en_q[S-1];
    ev = (m_edges(1) | m_edges(0)) & irq_mask8;
    if (|ev)           m_irq8 = 1;
    else if (irq_clr)  m_irq8 = 0;
    if (|ev[3:0])      m_irq4 = 1;
    else if (irq_clr)  m_irq4 = 0;
    m_on_prev = (m_phase == 2);
    m_hist = m_pad_q[S-1];
    case (m_phase)
      0: if (m_en_db) begin m_phase = 1; m_age = 0; end
      1: if (!m_en_db) m_phase = 0;
         else begin m_age++; if (m_age == G) m_phase = 2; end
      2: if (!m_en_db) begin m_phase = 3; m_idle = 0; end
      default: if (!m_idle) begin
                 if (cs_n_i) begin m_idle = 1; m_age = 0; end
               end else begin
                 m_age++;
                 if (m_age == G) m_phase = 0;
               end
    endcase
    if (en_s != m_en_db) begin
      m_run++;
      if (m_run == DB) begin m_en_db = !m_en_db; m_run = 0; end
    end else begin
      m_run = 0;
    end
    m_en_q.push_front(en_sw);   void'(m_en_q.pop_back());
    m_pad_q.push_front(pad_i8); void'(m_pad_q.pop_back());
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic compare();
    logic [7:0] gin, r, f, goe;
    bit pass;
    gin  = m_pad_q[S-1];
    r    = m_edges(1);
    f    = m_edges(0);
    pass = (m_phase == 2) || (m_phase == 3 && !m_idle);
    goe  = (m_phase == 2) ? gpio_oe8 : 8'h00;
    chk("ls4", ls4, m_phase);                  chk("ls8", ls8, m_phase);
    chk("gpio_in4", gin4, gin[3:0]);           chk("gpio_in8", gin8, gin);
    chk("rise4", rise4, r[3:0]);               chk("rise8", rise8, r);
    chk("fall4", fall4, f[3:0]);               chk("fall8", fall8, f);
    chk("irq4", irq4, m_irq4);                 chk("irq8", irq8, m_irq8);
    chk("gpio_oe4", pads4.pad_gpio_oe, goe[3:0]);
    chk("gpio_oe8", pads8.pad_gpio_oe, goe);
    chk("spi_oe", {pads8.pad_spi_oe, pads4.pad_spi_oe}, (m_phase != 0) ? 3 : 0);
    chk("sclk", {pads8.pad_sclk_o, pads4.pad_sclk_o}, (pass && sclk_i) ? 3 : 0);
    chk("mosi", {pads8.pad_mosi_o, pads4.pad_mosi_o}, (pass && mosi_i) ? 3 : 0);
    chk("cs_n", {pads8.pad_cs_n_o, pads4.pad_cs_n_o}, (!pass || cs_n_i) ? 3 : 0);
    chk("miso", {miso8, miso4}, (pass && miso_i) ? 3 : 0);
    if (m_phase == 2) begin
      chk("gpio_o4", pads4.pad_gpio_o, gpio_out8[3:0]);
      chk("gpio_o8", pads8.pad_gpio_o, gpio_out8);
    end
  endtask

  task automatic step();
    #1;
    compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1; en_sw = 0; irq_clr = 0; sclk_i = 0; mosi_i = 0; cs_n_i = 1; miso_i = 0;
    gpio_out8 = 8'h00; gpio_oe8 = 8'h00; irq_mask8 = 8'h00; pad_i8 = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ls", ls4, 0);
    chk("rst_cs_n", pads4.pad_cs_n_o, 1);
    chk("rst_spi_oe", pads4.pad_spi_oe, 0);
    chk("rst_irq", irq4, 0);
    chk("rst_gpio_in", gin4, 0);
    rst = 0;
    step();

    // enable rise: ARMING after 11 steps, held 4 cycles, then ON
    en_sw = 1; gpio_oe8 = 8'hFF; gpio_out8 = 8'hA5;
    steps(10);
    chk("t1_pre_arm", ls4, 0);
    step();
    chk("t1_arm", ls4, 1);
    chk("t1_arm_spi_oe", pads4.pad_spi_oe, 1);
    chk("t1_arm_cs_n", pads4.pad_cs_n_o, 1);
    chk("t1_arm_gpio_oe", pads4.pad_gpio_oe, 0);
    steps(3);
    chk("t1_arm_last", ls4, 1);
    step();
    chk("t1_on", ls4, 2);
    steps(2);

    // masked-in rising edge on channel 1, then unmasked channel 0
    irq_mask8 = 8'h02; irq_clr = 1; step(); irq_clr = 0;
    pad_i8[1] = 1; steps(2);
    chk("t4_rise", rise4, 4'b0010);
    step();
    chk("t4_pulse_end", rise4, 0);
    chk("t4_irq", irq4, 1);
    irq_clr = 1; step(); irq_clr = 0;
    chk("t4_clr", irq4, 0);
    pad_i8[0] = 1; steps(2);
    chk("t4_rise0", rise4, 4'b0001);
    step();
    chk("t4_irq_unmasked", irq4, 0);

    // edge and clear together: set wins; clear alone then drops irq
    pad_i8[1] = 0; steps(2);
    chk("t5_fall", fall4, 4'b0010);
    irq_clr = 1; step();
    chk("t5_set_wins", irq4, 1);
    step();
    chk("t5_clear", irq4, 0);
    irq_clr = 0;

    // drain with an open transaction
    cs_n_i = 0; en_sw = 0;
    for (int i = 0; i < 10; i++) begin sclk_i = ~sclk_i; step(); end
    chk("t3_still_on", ls4, 2);
    sclk_i = ~sclk_i; step();
    chk("t3_drain", ls4, 3);
    chk("t3_gpio_oe", pads4.pad_gpio_oe, 0);
    en_sw = 1;
    for (int i = 0; i < 5; i++) begin
      sclk_i = ~sclk_i; step();
      chk("t3_sclk_pass", pads4.pad_sclk_o, sclk_i);
    end
    en_sw = 0; cs_n_i = 1; sclk_i = 1; step();
    chk("t3_idle_ls", ls4, 3);
    chk("t3_idle_sclk", pads4.pad_sclk_o, 0);
    steps(3);
    chk("t3_idle_last", ls4, 3);
    step();
    chk("t3_off", ls4, 0);
    chk("t3_off_oe", {pads4.pad_spi_oe, pads4.pad_gpio_oe}, 0);

    // short enable pulses never pass debounce
    for (int p = 0; p < 4; p++) begin
      en_sw = 1; steps(7);
      en_sw = 0; steps(5);
      chk("t2_off", ls4, 0);
    end

    // reset during DRAINING, then channel 7 on the wide instance
    en_sw = 1; steps(30);
    pad_i8[1] = 1; irq_mask8 = 8'h02; steps(4);
    chk("t6_irq_set", irq4, 1);
    en_sw = 0; cs_n_i = 0; steps(14);
    chk("t6_drain", ls4, 3);
    rst = 1; step(); rst = 0;
    chk("t6_rst_ls", ls4, 0);
    chk("t6_rst_oe", {pads4.pad_spi_oe, pads4.pad_gpio_oe}, 0);
    chk("t6_rst_irq", irq4, 0);
    chk("t6_rst_cs_n", pads4.pad_cs_n_o, 1);
    en_sw = 1; cs_n_i = 1; steps(20);
    irq_mask8 = 8'h80; pad_i8[7] = 1; steps(2);
    chk("t6_rise7", rise8, 8'h80);
    chk("t6_irq8_pre", irq8, 0);
    step();
    chk("t6_irq8", irq8, 1);

    // randomized traffic
    for (int seg = 0; seg < 150; seg++) begin
      int len;
      len = $urandom_range(2, 40);
      en_sw = 1'($urandom_range(0, 1));
      irq_mask8 = 8'($urandom); gpio_oe8 = 8'($urandom); gpio_out8 = 8'($urandom);
      for (int c = 0; c < len; c++) begin
        sclk_i = 1'($urandom); mosi_i = 1'($urandom); miso_i = 1'($urandom);
        if ($urandom_range(0, 5) == 0) cs_n_i = ~cs_n_i;
        if ($urandom_range(0, 3) == 0) pad_i8[$urandom_range(0, 7)] ^= 1'b1;
        irq_clr = ($urandom_range(0, 5) == 0);
        rst = ($urandom_range(0, 399) == 0);
        step();
      end
    end
    rst = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
